// File: rtl/hm01b0_capture_ctrl_pkg.sv
// Shared geometry defaults and FSM state encoding for the hm01b0 capture slice.
package hm01b0_pkg;

    localparam int unsigned DEF_WIDTH       = 320;
    localparam int unsigned DEF_HEIGHT      = 240;
    localparam int unsigned DEF_STRIPE_ROWS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ARM,
        CAPTURE,
        DRAIN
    } state_t;

    // Two banks of STRIPE_ROWS lines each.
    function automatic int unsigned stripe_addr_w(input int unsigned width, input int unsigned rows);
        return $clog2(2 * width * rows);
    endfunction

endpackage

// File: rtl/hm01b0_capture_ctrl_if.sv
// Stripe buffer write port plus the stripe valid/done handshake toward the block formatter.
interface hm01b0_capture_ctrl_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              stripe_valid;
    logic              stripe_bank;
    logic              stripe_done;

    modport master (
        output wr_en, wr_addr, wr_data, stripe_valid, stripe_bank,
        input  stripe_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, stripe_valid, stripe_bank,
        output stripe_done
    );
endinterface

// File: rtl/hm01b0_capture_ctrl_edge_det.sv
// Single input register stage for the camera bus, with rise/fall pulses for hsync and vsync.
module hm01b0_edge_det (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pixdata,
    input  logic       hsync,
    input  logic       vsync,
    output logic [7:0] pix_q,
    output logic       hsync_q,
    output logic       vsync_q,
    output logic       hsync_rise,
    output logic       hsync_fall,
    output logic       vsync_rise,
    output logic       vsync_fall
);
    logic hsync_qq;
    logic vsync_qq;

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q    <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hsync_qq <= 1'b0;
            vsync_qq <= 1'b0;
        end else begin
            pix_q    <= pixdata;
            hsync_q  <= hsync;
            vsync_q  <= vsync;
            hsync_qq <= hsync_q;
            vsync_qq <= vsync_q;
        end
    end

    // Edges are aligned with the registered stage so they coincide with pix_q.
    assign hsync_rise = hsync_q & ~hsync_qq;
    assign hsync_fall = ~hsync_q & hsync_qq;
    assign vsync_rise = vsync_q & ~vsync_qq;
    assign vsync_fall = ~vsync_q & vsync_qq;

endmodule

// File: rtl/hm01b0_capture_ctrl.sv
// Single-frame capture from the hm01b0 stream into a two-bank stripe buffer with stripe handshake.
// Optional line/frame geometry checking is enabled by defining HM01B0_CAPTURE_GEOM_CHECK_EN.
module hm01b0_capture_ctrl
    import hm01b0_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned HEIGHT      = DEF_HEIGHT,
    parameter int unsigned STRIPE_ROWS = DEF_STRIPE_ROWS,
    parameter int unsigned ADDR_W      = stripe_addr_w(WIDTH, STRIPE_ROWS)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pixdata,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       frame_req,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       overflow,
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
    output logic       geom_err,
`endif
    hm01b0_capture_ctrl_if.master sbuf
);
    localparam int unsigned COL_W = $clog2(WIDTH + 1);
    localparam int unsigned ROW_W = $clog2(HEIGHT + 2);
    localparam int unsigned RIS_W = $clog2(STRIPE_ROWS + 1);

    localparam logic [COL_W-1:0]  WIDTH_C    = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0]  HEIGHT_C   = ROW_W'(HEIGHT);
    localparam logic [RIS_W-1:0]  RIS_FULL   = RIS_W'(STRIPE_ROWS);
    localparam logic [ADDR_W-1:0] BANK_OFS   = ADDR_W'(WIDTH * STRIPE_ROWS);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH);

    logic [7:0] pix_q;
    logic       hsync_q, vsync_q;
    logic       hsync_rise, hsync_fall, vsync_rise, vsync_fall;

    state_t             state, state_n;
    logic [COL_W-1:0]   col, col_n, col_cur;
    logic [ROW_W-1:0]   row, row_n;
    logic [RIS_W-1:0]   ris, ris_n;
    logic               wr_bank, wr_bank_n;
    logic               rd_bank, rd_bank_n;
    logic [1:0]         bank_full, full_n;
    logic               busy_n, done_n, ovf_n;
    logic               pix_ok, wr_en_c;
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
    logic               geom_n;
`endif

    hm01b0_edge_det u_edge (
        .clock      (clock),
        .reset      (reset),
        .pixdata    (pixdata),
        .hsync      (hsync),
        .vsync      (vsync),
        .pix_q      (pix_q),
        .hsync_q    (hsync_q),
        .vsync_q    (vsync_q),
        .hsync_rise (hsync_rise),
        .hsync_fall (hsync_fall),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            ris        <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            bank_full  <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
            geom_err   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            ris        <= ris_n;
            wr_bank    <= wr_bank_n;
            rd_bank    <= rd_bank_n;
            bank_full  <= full_n;
            frame_busy <= busy_n;
            frame_done <= done_n;
            overflow   <= ovf_n;
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
            geom_err   <= geom_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        ris_n     = ris;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        full_n    = bank_full;
        busy_n    = frame_busy;
        done_n    = 1'b0;
        ovf_n     = overflow;
        wr_en_c   = 1'b0;
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
        geom_n    = geom_err;
`endif
        // A fresh line always starts at column 0, even in its first pixel cycle.
        col_cur = hsync_rise ? '0 : col;
        pix_ok  = (state == CAPTURE) && hsync_q && vsync_q &&
                  (col_cur < WIDTH_C) && (row < HEIGHT_C);

        // Release is applied first so a same-cycle fill of the released bank still wins.
        if (sbuf.stripe_done && bank_full[rd_bank]) begin
            full_n[rd_bank] = 1'b0;
            rd_bank_n       = ~rd_bank;
        end

        unique case (state)
            IDLE: begin
                if (frame_req) begin
                    ovf_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SYNC;
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
                    geom_n  = 1'b0;
`endif
                end
            end
            SYNC: begin
                if (!vsync_q) state_n = ARM;
            end
            ARM: begin
                if (vsync_rise) begin
                    col_n     = '0;
                    row_n     = '0;
                    ris_n     = '0;
                    wr_bank_n = 1'b0;
                    rd_bank_n = 1'b0;
                    state_n   = CAPTURE;
                end
            end
            CAPTURE: begin
                col_n = col_cur;
                if (pix_ok) begin
                    col_n = col_cur + 1'b1;
                    if (bank_full[wr_bank]) ovf_n   = 1'b1;
                    else                    wr_en_c = 1'b1;
                end
                if (hsync_fall) begin
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
                    if (col != WIDTH_C) geom_n = 1'b1;
`endif
                    col_n = '0;
                    if (row <= HEIGHT_C) row_n = row + 1'b1;
                    ris_n = ris + 1'b1;
                    if (ris_n == RIS_FULL) begin
                        full_n[wr_bank] = 1'b1;
                        wr_bank_n       = ~wr_bank;
                        ris_n           = '0;
                    end
                end
                // ris_n/row_n already include a line ending in this same cycle.
                if (vsync_fall) begin
                    if (ris_n != '0) begin
                        full_n[wr_bank] = 1'b1;
                        ris_n           = '0;
                    end
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
                    if (row_n != HEIGHT_C) geom_n = 1'b1;
`endif
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (bank_full == '0) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sbuf.wr_en        = wr_en_c;
    assign sbuf.wr_addr      = (wr_bank ? BANK_OFS : '0) + ADDR_W'(ris) * ROW_STRIDE + ADDR_W'(col_cur);
    assign sbuf.wr_data      = pix_q;
    assign sbuf.stripe_valid = bank_full[rd_bank];
    assign sbuf.stripe_bank  = rd_bank;

endmodule

// File: tb/tb_hm01b0_capture_ctrl.sv
// Directed bench for hm01b0_capture_ctrl on a reduced 16x32 geometry (4 stripes of 8 lines).
module tb_hm01b0_capture_ctrl;
    import hm01b0_pkg::*;

    localparam int W   = 16;
    localparam int H   = 32;
    localparam int SR  = 8;
    localparam int AW  = 8;
    localparam int BUF = 2 * W * SR;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pixdata = '0;
    logic       hsync = 1'b0, vsync = 1'b0, frame_req = 1'b0;
    logic       frame_busy, frame_done, overflow;
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
    logic       geom_err;
`endif
    logic       auto_done = 1'b0, man_done = 1'b0;
    bit         auto_mode = 1'b0;
    bit         sb_on = 1'b0;
    int         seed = 0;

    hm01b0_capture_ctrl_if #(.ADDR_W(AW)) sbuf_if ();
    assign sbuf_if.stripe_done = auto_done | man_done;

    hm01b0_capture_ctrl #(
        .WIDTH(W), .HEIGHT(H), .STRIPE_ROWS(SR), .ADDR_W(AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pixdata    (pixdata),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_req  (frame_req),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .overflow   (overflow),
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
        .geom_err   (geom_err),
`endif
        .sbuf       (sbuf_if.master)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed { logic [7:0] d; logic [AW-1:0] a; } wr_t;
    wr_t        exp_q[$];
    logic [AW-1:0] waddr [4096];
    logic       banks [64];
    int         wr_total = 0, st_total = 0, done_total = 0;

    always @(negedge clock) begin
        if (sbuf_if.wr_en === 1'b1) begin
            if (wr_total < 4096) waddr[wr_total] = sbuf_if.wr_addr;
            wr_total++;
            if (sb_on) begin
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(sbuf_if.wr_data), 32'(e.d));
                    chk("sb_addr", 32'(sbuf_if.wr_addr), 32'(e.a));
                end else begin
                    chk("sb_extra_write", 32'(sbuf_if.wr_en), 32'd0);
                end
            end
        end
        if (frame_done === 1'b1) done_total++;
        if (sbuf_if.stripe_valid === 1'b1 && sbuf_if.stripe_done === 1'b1) begin
            if (st_total < 64) banks[st_total] = sbuf_if.stripe_bank;
            st_total++;
        end
    end

    // Consumer model: releases each presented stripe 10 cycles after it appears.
    always begin
        @(posedge clock); #1;
        if (auto_mode && sbuf_if.stripe_valid === 1'b1) begin
            repeat (10) begin @(posedge clock); #1; end
            auto_done = 1'b1;
            @(posedge clock); #1;
            auto_done = 1'b0;
        end
    end

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * W + c) * 7 + seed);
    endfunction

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic vs_on();
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic vs_off();
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic line(input int r, input int n, input int gap);
        wr_t e;
        for (int c = 0; c < n; c++) begin
            hsync   = 1'b1;
            pixdata = pix(r, c);
            if (sb_on) begin
                e.d = pix(r, c);
                e.a = AW'((r * W + c) % BUF);
                exp_q.push_back(e);
            end
            tick();
        end
        hsync = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic frame(input int short_row);
        vs_on();
        for (int r = 0; r < H; r++) line(r, (r == short_row) ? W - 1 : W, 4);
        vs_off();
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (frame_busy === 1'b1 && k < 400) begin
            tick();
            k++;
        end
        chk(tag, 32'(frame_busy), 32'd0);
        repeat (2) tick();
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_frame_busy"},   32'(frame_busy), 32'd0);
        chk({pfx, "_frame_done"},   32'(frame_done), 32'd0);
        chk({pfx, "_overflow"},     32'(overflow), 32'd0);
        chk({pfx, "_wr_en"},        32'(sbuf_if.wr_en), 32'd0);
        chk({pfx, "_wr_addr"},      32'(sbuf_if.wr_addr), 32'd0);
        chk({pfx, "_wr_data"},      32'(sbuf_if.wr_data), 32'd0);
        chk({pfx, "_stripe_valid"}, 32'(sbuf_if.stripe_valid), 32'd0);
        chk({pfx, "_stripe_bank"},  32'(sbuf_if.stripe_bank), 32'd0);
        chk({pfx, "_state"},        32'(dut.state), 32'(IDLE));
        chk({pfx, "_bank_full"},    32'(dut.bank_full), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, st_base, dn_base;

        // Power-on reset
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk_reset_state("por");
        reset = 1'b0;
        tick();

        // stripe_done with nothing presented is ignored
        pulse_done();
        @(negedge clock);
        chk("idle_done_bank", 32'(sbuf_if.stripe_bank), 32'd0);
        chk("idle_done_rd",   32'(dut.rd_bank), 32'd0);

        // frame_req mid-frame: nothing written until the next vsync rise
        auto_mode = 1'b1;
        seed      = 3;
        base      = wr_total;
        vs_on();
        line(0, W, 4);
        line(1, W, 4);
        pulse_req();
        @(negedge clock);
        chk("busy_after_req", 32'(frame_busy), 32'd1);
        for (int r = 2; r < H; r++) line(r, W, 4);
        vs_off();
        chk("no_wr_mid_frame", 32'(wr_total - base), 32'd0);

        // Full frame with a prompt consumer
        base    = wr_total;
        st_base = st_total;
        dn_base = done_total;
        sb_on   = 1'b1;
        frame(-1);
        wait_idle("full_frame_idle");
        sb_on = 1'b0;
        chk("full_wr_count",   32'(wr_total - base), 32'(W * H));
        chk("first_addr",      32'(waddr[base]), 32'd0);
        chk("stripe0_last",    32'(waddr[base + W * SR - 1]), 32'd127);
        chk("stripe1_first",   32'(waddr[base + W * SR]), 32'd128);
        chk("frame_last_addr", 32'(waddr[base + W * H - 1]), 32'd255);
        chk("stripe_count",    32'(st_total - st_base), 32'd4);
        for (int i = 0; i < 4; i++) chk("stripe_bank_seq", 32'(banks[st_base + i]), 32'(i % 2));
        chk("done_once",       32'(done_total - dn_base), 32'd1);
        chk("no_overflow",     32'(overflow), 32'd0);
        chk("sb_drained",      32'(exp_q.size()), 32'd0);
`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
        chk("geom_clean", 32'(geom_err), 32'd0);
`endif

        // Consumer stalls: overrun on the first pixel of stripe 2
        auto_mode = 1'b0;
        seed      = 5;
        base      = wr_total;
        dn_base   = done_total;
        pulse_req();
        vs_on();
        for (int r = 0; r < 2 * SR; r++) line(r, W, 4);
        chk("ovf_before_stripe2", 32'(overflow), 32'd0);
        line(2 * SR, W, 4);
        chk("ovf_at_stripe2", 32'(overflow), 32'd1);
        for (int r = 2 * SR + 1; r < H; r++) line(r, W, 4);
        vs_off();
        repeat (20) tick();
        chk("ovf_wr_count",   32'(wr_total - base), 32'(2 * W * SR));
        chk("ovf_drain_busy", 32'(frame_busy), 32'd1);
        chk("ovf_valid",      32'(sbuf_if.stripe_valid), 32'd1);
        chk("ovf_bank0",      32'(sbuf_if.stripe_bank), 32'd0);
        pulse_done();
        @(negedge clock);
        chk("ovf_bank1",      32'(sbuf_if.stripe_bank), 32'd1);
        pulse_done();
        wait_idle("ovf_idle");
        chk("ovf_done_once",  32'(done_total - dn_base), 32'd1);
        chk("ovf_sticky",     32'(overflow), 32'd1);

        // Release of bank 0 in the same cycle bank 1 fills
        dn_base = done_total;
        pulse_req();
        @(negedge clock);
        chk("req_clears_ovf", 32'(overflow), 32'd0);
        vs_on();
        for (int r = 0; r < 2 * SR - 1; r++) line(r, W, 4);
        line(2 * SR - 1, W, 1);
        man_done = 1'b1;
        @(negedge clock);
        chk("same_pre_valid", 32'(sbuf_if.stripe_valid), 32'd1);
        chk("same_pre_bank",  32'(sbuf_if.stripe_bank), 32'd0);
        tick();
        man_done = 1'b0;
        @(negedge clock);
        chk("same_bank_full", 32'(dut.bank_full), 32'b10);
        chk("same_valid",     32'(sbuf_if.stripe_valid), 32'd1);
        chk("same_bank",      32'(sbuf_if.stripe_bank), 32'd1);
        auto_mode = 1'b1;
        for (int r = 2 * SR; r < H; r++) line(r, W, 4);
        vs_off();
        wait_idle("same_idle");
        chk("same_no_ovf",    32'(overflow), 32'd0);
        chk("same_done_once", 32'(done_total - dn_base), 32'd1);

        // Reset in the middle of a capture
        pulse_req();
        vs_on();
        for (int r = 0; r < 10; r++) line(r, W, 4);
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk_reset_state("mid");
        reset = 1'b0;
        base  = wr_total;
        for (int r = 10; r < H; r++) line(r, W, 4);
        vs_off();
        frame(-1);
        chk("post_reset_no_wr",   32'(wr_total - base), 32'd0);
        chk("post_reset_no_busy", 32'(frame_busy), 32'd0);

`ifdef HM01B0_CAPTURE_GEOM_CHECK_EN
        // One short line flags a geometry error, cleared by the next request
        base = wr_total;
        pulse_req();
        frame(5);
        wait_idle("geom_idle");
        chk("geom_wr_count", 32'(wr_total - base), 32'(W * H - 1));
        chk("geom_set",      32'(geom_err), 32'd1);
        pulse_req();
        @(negedge clock);
        chk("geom_cleared",  32'(geom_err), 32'd0);
        frame(-1);
        wait_idle("geom_clean_idle");
        chk("geom_stays_clear", 32'(geom_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
